// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: synchronizes and edge-detects raw interrupt sources, latches
// them as pending, masks and arbitrates them by fixed priority (lowest index
// wins), and presents one request to the CPU under an int_req/int_ack
// handshake. No nesting: nothing new is requested until the CPU signals eret.
module interrupt_ctrl #(
    parameter int          NUM_SRC       = 2,
    parameter int          ID_W          = 1,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0008
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] pending,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        int_vector,
    input  logic               int_ack,
    input  logic               eret,
    output logic               in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Synchronizer (s1, s2) plus edge-detect flop (s3) per source
    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_s3;

    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    state_t             r_state;
    logic [ID_W-1:0]    r_id;

    state_t             w_state_next;
    logic [NUM_SRC-1:0] w_event;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_id_onehot;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [ID_W-1:0]    w_winner;
    logic               w_any;
    logic               w_ack_take;
    logic               w_id_live;

    // Rising edge of a synchronized request is one event
    assign w_event    = r_s2 & ~r_s3;
    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;

    // int_ack only counts while a request is outstanding
    assign w_ack_take = (r_state == ST_REQ) && int_ack;

    // Per-source decode of the captured id, the ack clear and pending update.
    // A new event wins over a simultaneous clear so that event is not lost.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_id_onehot[gi]    = (r_id == ID_W'(gi));
            assign w_clr[gi]          = w_ack_take & w_id_onehot[gi];
            assign w_pending_next[gi] = w_event[gi] | (r_pending[gi] & ~w_clr[gi]);
        end
    endgenerate

    // The captured source is still requestable only while pending and unmasked
    assign w_id_live = |(w_id_onehot & w_eligible);

    // Two-flop synchronizer and edge-history flop; reset discards in-flight events
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= irq_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Mask register; all sources enabled out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    // Pending latch: set by events, cleared only by an accepted int_ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Fixed-priority pick: scanning downwards leaves the lowest set index
    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // Capture the winner on the IDLE->REQ decision; held through REQ and SERVICE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id <= '0;
        end else if ((r_state == ST_IDLE) && w_any) begin
            r_id <= w_winner;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: ack beats withdraw; no re-arbitration while in REQ
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_next = ST_SERVICE;
                end else if (!w_id_live) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the registered state only
    always_comb begin
        int_req    = 1'b0;
        in_service = 1'b0;
        case (r_state)
            ST_REQ:     int_req    = 1'b1;
            ST_SERVICE: in_service = 1'b1;
            default: begin
                int_req    = 1'b0;
                in_service = 1'b0;
            end
        endcase
    end

    assign mask       = r_mask;
    assign pending    = r_pending;
    assign int_id     = r_id;
    // Low 32 bits only; wraps around by design
    assign int_vector = VECTOR_BASE + (32'(r_id) * VECTOR_STRIDE);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Testbench for interrupt_ctrl: scoreboard of expected requests (id/vector)
// pushed when sources are raised, popped when the DUT asserts int_req.
module tb_interrupt_ctrl;

    localparam int NUM_SRC = 2;
    localparam int ID_W    = 1;

    logic               clk;
    logic               rstn;
    logic [NUM_SRC-1:0] irq_in;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic               int_req;
    logic [ID_W-1:0]    int_id;
    logic [31:0]        int_vector;
    logic               int_ack;
    logic               eret;
    logic               in_service;

    int n_cmp;
    int n_err;
    int exp_q[$];

    interrupt_ctrl #(
        .NUM_SRC      (NUM_SRC),
        .ID_W         (ID_W),
        .VECTOR_BASE  (32'h0000_0100),
        .VECTOR_STRIDE(32'h0000_0008)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .mask      (mask),
        .pending   (pending),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_vector(int_vector),
        .int_ack   (int_ack),
        .eret      (eret),
        .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic write_mask(input logic [NUM_SRC-1:0] val);
        mask_we    = 1'b1;
        mask_wdata = val;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    // Wait (bounded) for int_req, then pop the expected source and compare
    task automatic expect_req(input string tag);
        int n;
        int exp_id;
        n = 0;
        while (!int_req && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, 32'(int_req), 32'd1);
        if (!int_req) return;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        exp_id = exp_q.pop_front();
        check({tag, "_id"}, 32'(int_id), 32'(exp_id));
        check({tag, "_vector"}, int_vector, 32'h100 + 32'(exp_id) * 32'h8);
        $display("txn %s: int_id=%0d int_vector=%h (expected id %0d)", tag, int_id, int_vector, exp_id);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rstn       = 1'b0;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        int_ack    = 1'b0;
        eret       = 1'b0;
        ticks(3);

        // Reset values while held in reset
        check("rst_mask", 32'(mask), 32'h3);
        check("rst_vector", int_vector, 32'h100);
        rstn = 1'b1;

        // Idle after reset for 20 cycles
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_state", {29'd0, pending, int_req, in_service}, 32'd0);
        end
        check("idle_mask", 32'(mask), 32'h3);
        check("idle_vector", int_vector, 32'h100);

        // Single event on source 1: pending after edge 3, request after edge 4
        irq_in[1] = 1'b1;
        exp_q.push_back(1);
        ticks(2);
        check("single_pend_e2", 32'(pending), 32'h0);
        tick();
        check("single_pend_e3", 32'(pending), 32'h2);
        check("single_noreq_e3", 32'(int_req), 32'd0);
        tick();
        check("single_req_e4", 32'(int_req), 32'd1);
        expect_req("single");
        pulse_ack();
        check("single_ack_pend", 32'(pending), 32'h0);
        check("single_ack_insvc", 32'(in_service), 32'd1);
        check("single_ack_req", 32'(int_req), 32'd0);
        ticks(3);
        // Level still high: no second event
        check("single_level_pend", 32'(pending), 32'h0);
        pulse_eret();
        check("single_eret_insvc", 32'(in_service), 32'd0);
        check("single_eret_req", 32'(int_req), 32'd0);
        irq_in[1] = 1'b0;
        ticks(4);

        // Priority and freeze: id 1 already requested, id 0 arrives later
        irq_in[1] = 1'b1;
        exp_q.push_back(1);
        ticks(2);
        irq_in[0] = 1'b1;
        exp_q.push_back(0);
        ticks(2);
        expect_req("prio_first");
        ticks(3);
        check("prio_pend_both", 32'(pending), 32'h3);
        check("prio_frozen_id", 32'(int_id), 32'd1);
        check("prio_frozen_vec", int_vector, 32'h108);
        pulse_ack();
        check("prio_ack_pend", 32'(pending), 32'h1);
        pulse_eret();
        check("prio_idle_req", 32'(int_req), 32'd0);
        tick();
        expect_req("prio_second");
        pulse_ack();
        pulse_eret();
        irq_in = '0;
        ticks(4);

        // Masking keeps pending latched but suppresses the request
        write_mask(2'b10);
        check("mask_readback", 32'(mask), 32'h2);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        ticks(6);
        check("mask_pend", 32'(pending), 32'h1);
        check("mask_noreq", 32'(int_req), 32'd0);
        exp_q.push_back(0);
        write_mask(2'b11);
        check("unmask_noreq_yet", 32'(int_req), 32'd0);
        tick();
        check("unmask_req", 32'(int_req), 32'd1);
        expect_req("unmask");

        // Withdraw: masking the requested source drops int_req
        write_mask(2'b10);
        tick();
        check("withdraw_req", 32'(int_req), 32'd0);
        check("withdraw_pend", 32'(pending), 32'h1);
        check("withdraw_insvc", 32'(in_service), 32'd0);
        exp_q.push_back(0);
        write_mask(2'b11);
        tick();
        expect_req("rerequest");

        // Ack and mask write in the same cycle: ack wins
        mask_we    = 1'b1;
        mask_wdata = 2'b10;
        int_ack    = 1'b1;
        tick();
        mask_we = 1'b0;
        int_ack = 1'b0;
        check("ackwins_insvc", 32'(in_service), 32'd1);
        check("ackwins_pend", 32'(pending), 32'h0);
        check("ackwins_mask", 32'(mask), 32'h2);
        pulse_eret();
        write_mask(2'b11);
        ticks(2);

        // Spurious handshake pulses in IDLE
        pulse_eret();
        check("spur_eret", {29'd0, pending, int_req, in_service}, 32'd0);
        pulse_ack();
        check("spur_ack", {29'd0, pending, int_req, in_service}, 32'd0);
        ticks(2);

        // Asynchronous reset during SERVICE, with an event in flight
        irq_in[1] = 1'b1;
        exp_q.push_back(1);
        expect_req("rst_setup");
        pulse_ack();
        check("rst_pre_insvc", 32'(in_service), 32'd1);
        irq_in[0] = 1'b1;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_insvc", 32'(in_service), 32'd0);
        check("rst_async_req", 32'(int_req), 32'd0);
        check("rst_async_pend", 32'(pending), 32'h0);
        check("rst_async_mask", 32'(mask), 32'h3);
        check("rst_async_id", 32'(int_id), 32'd0);
        check("rst_async_vec", int_vector, 32'h100);
        irq_in = '0;
        tick();
        rstn = 1'b1;
        ticks(5);
        check("rst_after_pend", 32'(pending), 32'h0);
        check("rst_after_req", 32'(int_req), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
